// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and address-check helper for the memory port arbiter.
//  Revision : 1.0
// ============================================================================

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif

package mem_arb_pkg;

    localparam int unsigned C_MEM_AW = `MEM_ADDR_WIDTH;
    localparam int unsigned C_MEM_DW = `MEM_DATA_WIDTH;
    localparam int unsigned C_CNT_W  = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } mem_owner_t;

    // Word-misaligned, or (when checking) any address bit above the word index set.
    function automatic logic addr_err(input logic [31:0] addr, input logic check);
        logic [31:0] w_upper;
        w_upper = addr >> (C_MEM_AW + 2);
        return (addr[1:0] != 2'b00) || (check && (w_upper != 32'd0));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_starve_ctr
//  Purpose  : Saturating count of consecutive fetch arbitration losses.
//  Revision : 1.0
// ============================================================================

module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic lose_i,
    input  logic win_idle_i,
    output logic at_limit_o
);

    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(LIMIT);

    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (win_idle_i) begin
            cnt_d = '0;
        end else if (lose_i && (cnt_q != C_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares a one-cycle-latency single-port memory between fetch and data.
//  Revision : 1.0
// ============================================================================

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          ADDR_CHECK   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    // fetch port
    input  logic                       if_req_valid,
    input  logic [31:0]                if_req_addr,
    output logic                       if_req_ready,
    output logic                       if_resp_valid,
    output logic [31:0]                if_resp_rdata,
    output logic                       if_resp_err,
    // data port
    input  logic                       d_req_valid,
    input  logic [31:0]                d_req_addr,
    input  logic                       d_req_we,
    input  logic [`MEM_DATA_WIDTH-1:0] d_req_wdata,
    output logic                       d_req_ready,
    output logic                       d_resp_valid,
    output logic [31:0]                d_resp_rdata,
    output logic                       d_resp_err,
    // memory macro
    output logic [31:0]                mem_addr,
    output logic [`MEM_DATA_WIDTH-1:0] mem_wdata,
    output logic                       mem_rw,
    input  logic [31:0]                mem_rdata
);

    logic       w_if_err;
    logic       w_d_err;
    logic       w_at_limit;
    logic       w_gnt_if;
    logic       w_gnt_d;
    logic       w_if_own;
    logic       w_d_own;

    mem_owner_t owner_q;
    mem_owner_t owner_d;
    logic       err_q;
    logic       err_d;

    assign w_if_err = addr_err(if_req_addr, ADDR_CHECK);
    assign w_d_err  = addr_err(d_req_addr,  ADDR_CHECK);

    // Data wins by default; fetch takes a contested cycle once it has lost STARVE_LIMIT in a row.
    always_comb begin
        w_gnt_d  = 1'b0;
        w_gnt_if = 1'b0;
        if (!reset) begin
            if (d_req_valid && !(if_req_valid && w_at_limit)) begin
                w_gnt_d = 1'b1;
            end else if (if_req_valid) begin
                w_gnt_if = 1'b1;
            end
        end
    end

    assign if_req_ready = w_gnt_if;
    assign d_req_ready  = w_gnt_d;

    mem_arb_starve_ctr #(
        .LIMIT      (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .reset      (reset),
        .lose_i     (if_req_valid && w_gnt_d),
        .win_idle_i (w_gnt_if || !if_req_valid),
        .at_limit_o (w_at_limit)
    );

    always_comb begin
        mem_addr = 32'd0;
        if (w_gnt_d) begin
            mem_addr = d_req_addr;
        end else if (w_gnt_if) begin
            mem_addr = if_req_addr;
        end
    end

    assign mem_wdata = d_req_wdata;
    assign mem_rw    = w_gnt_d && d_req_we && !w_d_err;

    always_comb begin
        owner_d = OWN_NONE;
        err_d   = 1'b0;
        if (w_gnt_d) begin
            owner_d = OWN_D;
            err_d   = w_d_err;
        end else if (w_gnt_if) begin
            owner_d = OWN_IF;
            err_d   = w_if_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Gating with reset drops a response whose issue preceded a reset cycle.
    assign w_if_own = (owner_q == OWN_IF) && !reset;
    assign w_d_own  = (owner_q == OWN_D)  && !reset;

    assign if_resp_valid = w_if_own;
    assign if_resp_err   = w_if_own && err_q;
    assign if_resp_rdata = (w_if_own && !err_q) ? mem_rdata : 32'd0;

    assign d_resp_valid  = w_d_own;
    assign d_resp_err    = w_d_own && err_q;
    assign d_resp_rdata  = (w_d_own && !err_q) ? mem_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter with a memory model.
//  Revision : 1.0
// ============================================================================

module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic                clk;
    logic                reset;
    logic                if_req_valid;
    logic [31:0]         if_req_addr;
    logic                if_req_ready;
    logic                if_resp_valid;
    logic [31:0]         if_resp_rdata;
    logic                if_resp_err;
    logic                d_req_valid;
    logic [31:0]         d_req_addr;
    logic                d_req_we;
    logic [C_MEM_DW-1:0] d_req_wdata;
    logic                d_req_ready;
    logic                d_resp_valid;
    logic [31:0]         d_resp_rdata;
    logic                d_resp_err;
    logic [31:0]         mem_addr;
    logic [C_MEM_DW-1:0] mem_wdata;
    logic                mem_rw;
    logic [31:0]         mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT  (4),
        .ADDR_CHECK    (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_resp_valid (if_resp_valid),
        .if_resp_rdata (if_resp_rdata),
        .if_resp_err   (if_resp_err),
        .d_req_valid   (d_req_valid),
        .d_req_addr    (d_req_addr),
        .d_req_we      (d_req_we),
        .d_req_wdata   (d_req_wdata),
        .d_req_ready   (d_req_ready),
        .d_resp_valid  (d_resp_valid),
        .d_resp_rdata  (d_resp_rdata),
        .d_resp_err    (d_resp_err),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rw        (mem_rw),
        .mem_rdata     (mem_rdata)
    );

    // Single-port memory: registered read of the old word, write in the same edge.
    logic [31:0] mem [0:(1<<C_MEM_AW)-1];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[C_MEM_AW+1:2]];
        if (mem_rw) mem[mem_addr[C_MEM_AW+1:2]] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
    task automatic step(input logic rst, input logic iv, input logic [31:0] ia,
                        input logic dv, input logic [31:0] da, input logic we,
                        input logic [31:0] wd);
        @(negedge clk);
        reset        = rst;
        if_req_valid = iv;
        if_req_addr  = ia;
        d_req_valid  = dv;
        d_req_addr   = da;
        d_req_we     = we;
        d_req_wdata  = wd;
        #1;
    endtask

    logic [9:0] pat10;
    logic [4:0] pat5;
    logic       prev_if;

    initial begin
        reset = 1'b1; if_req_valid = 1'b0; if_req_addr = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0;

        // reset holds ports idle even with both requesting
        step(1, 1, 32'h4, 1, 32'h0, 1, 32'hAAAA_AAAA);
        check("rst_if_rdy", {31'd0, if_req_ready}, 32'd0);
        check("rst_d_rdy",  {31'd0, d_req_ready},  32'd0);
        check("rst_rw",     {31'd0, mem_rw},       32'd0);
        check("rst_addr",   mem_addr,              32'd0);
        step(1, 1, 32'h4, 1, 32'h0, 1, 32'hAAAA_AAAA);
        check("rst_resp",   {30'd0, if_resp_valid, d_resp_valid}, 32'd0);

        // preload 0x0/0x4/0x8 through the data port
        step(0, 0, 0, 1, 32'h0, 1, 32'h11);
        check("pre_d_rdy", {31'd0, d_req_ready}, 32'd1);
        check("pre_rw",    {31'd0, mem_rw},      32'd1);
        check("pre_resp0", {31'd0, d_resp_valid}, 32'd0);
        step(0, 0, 0, 1, 32'h4, 1, 32'h22);
        check("pre_ack",   {31'd0, d_resp_valid}, 32'd1);
        step(0, 0, 0, 1, 32'h8, 1, 32'h33);

        // fetch-only back to back
        step(0, 1, 32'h0, 0, 0, 0, 0);
        check("f0_rdy",  {31'd0, if_req_ready}, 32'd1);
        check("f0_ack",  {31'd0, d_resp_valid}, 32'd1);
        check("f0_rw",   {31'd0, mem_rw},       32'd0);
        step(0, 1, 32'h4, 0, 0, 0, 0);
        check("f1_rdy",  {31'd0, if_req_ready}, 32'd1);
        check("f1_rv",   {31'd0, if_resp_valid}, 32'd1);
        check("f1_data", if_resp_rdata, 32'h11);
        step(0, 1, 32'h8, 0, 0, 0, 0);
        check("f2_rdy",  {31'd0, if_req_ready}, 32'd1);
        check("f2_data", if_resp_rdata, 32'h22);
        step(0, 0, 0, 0, 0, 0, 0);
        check("f3_rv",   {31'd0, if_resp_valid}, 32'd1);
        check("f3_data", if_resp_rdata, 32'h33);

        // write then same-address read
        step(0, 0, 0, 1, 32'h8, 1, 32'hDEAD_BEEF);
        check("w_rdy",   {31'd0, d_req_ready}, 32'd1);
        check("w_rw",    {31'd0, mem_rw},      32'd1);
        check("w_addr",  mem_addr,  32'h8);
        check("w_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("w_ifrv",  {31'd0, if_resp_valid}, 32'd0);
        step(0, 0, 0, 1, 32'h8, 0, 0);
        check("r_ack",   {31'd0, d_resp_valid}, 32'd1);
        check("r_old",   d_resp_rdata, 32'h33);
        check("r_rw",    {31'd0, mem_rw}, 32'd0);
        check("r_ifrv",  {31'd0, if_resp_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("r_rv",    {31'd0, d_resp_valid}, 32'd1);
        check("r_new",   d_resp_rdata, 32'hDEAD_BEEF);
        check("r_err",   {31'd0, d_resp_err}, 32'd0);
        check("r_ifrv2", {31'd0, if_resp_valid}, 32'd0);

        // idle cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check("idle_rw",   {31'd0, mem_rw}, 32'd0);
            check("idle_addr", mem_addr, 32'd0);
            check("idle_rv",   {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
            check("idle_rd",   if_resp_rdata | d_resp_rdata, 32'd0);
        end

        // both requesting: D,D,D,D,IF repeating
        pat10   = 10'b10000_10000;
        prev_if = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h4, 1, 32'h0, 0, 0);
            check("stv_d_rdy",  {31'd0, d_req_ready},  {31'd0, ~pat10[i]});
            check("stv_if_rdy", {31'd0, if_req_ready}, {31'd0, pat10[i]});
            check("stv_addr",   mem_addr, pat10[i] ? 32'h4 : 32'h0);
            check("stv_if_rv",  {31'd0, if_resp_valid}, {31'd0, prev_if});
            prev_if = pat10[i];
        end
        step(0, 0, 0, 0, 0, 0, 0);
        check("stv_if_data", if_resp_rdata, 32'h22);

        // address errors
        step(0, 0, 0, 1, 32'h6, 0, 0);
        check("e0_rdy", {31'd0, d_req_ready}, 32'd1);
        check("e0_rw",  {31'd0, mem_rw}, 32'd0);
        step(0, 0, 0, 1, 32'h8000_0000, 1, 32'h1234_5678);
        check("e1_rdy", {31'd0, d_req_ready}, 32'd1);
        check("e1_rw",  {31'd0, mem_rw}, 32'd0);
        check("e1_rv",  {31'd0, d_resp_valid}, 32'd1);
        check("e1_err", {31'd0, d_resp_err}, 32'd1);
        check("e1_rd",  d_resp_rdata, 32'd0);
        step(0, 0, 0, 1, 32'h0, 0, 0);
        check("e2_err", {31'd0, d_resp_err}, 32'd1);
        check("e2_rd",  d_resp_rdata, 32'd0);
        step(0, 1, 32'h2, 0, 0, 0, 0);
        check("e3_rdy", {31'd0, if_req_ready}, 32'd1);
        check("e3_err", {31'd0, d_resp_err}, 32'd0);
        check("e3_mem", d_resp_rdata, 32'h11);
        step(0, 1, 32'h1000, 0, 0, 0, 0);
        check("e4_err", {31'd0, if_resp_err}, 32'd1);
        check("e4_rd",  if_resp_rdata, 32'd0);
        check("e4_drv", {31'd0, d_resp_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("e5_rv",  {31'd0, if_resp_valid}, 32'd1);
        check("e5_err", {31'd0, if_resp_err}, 32'd1);

        // reset after accepted read with the starvation count part-way up
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h4, 1, 32'h8, 0, 0);
            check("s_d_rdy", {31'd0, d_req_ready}, 32'd1);
        end
        step(1, 1, 32'h4, 1, 32'h8, 0, 0);
        check("s_rst_rdy", {30'd0, if_req_ready, d_req_ready}, 32'd0);
        check("s_rst_rv",  {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
        check("s_rst_rw",  {31'd0, mem_rw}, 32'd0);
        check("s_rst_addr", mem_addr, 32'd0);
        pat5 = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h4, 1, 32'h8, 0, 0);
            check("p_d_rdy",  {31'd0, d_req_ready},  {31'd0, ~pat5[i]});
            check("p_if_rdy", {31'd0, if_req_ready}, {31'd0, pat5[i]});
            if (i == 0) check("p_drop", {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        check("p_if_rv", {31'd0, if_resp_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, one-cycle-latency `memory` macro between the instruction-fetch port (read-only) and the load/store data port (read/write).
- Grants at most one access per cycle and drives `mem_addr`/`mem_wdata`/`mem_rw` combinationally in the grant cycle.
- Tracks the in-flight access for one cycle and routes the memory's registered read data back to its owner.
- Data port has fixed priority; a starvation guard bounds fetch stalls. Misaligned and out-of-range requests are rejected without touching memory.

Parameters:
- STARVE_LIMIT, 4, consecutive lost arbitration cycles after which fetch wins the next contested cycle (legal range 1..15).
- ADDR_CHECK, 1, 1 = error on addr[31:`MEM_ADDR_WIDTH+2] != 0; 0 = upper bits ignored.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch byte address
- if_req_ready  out  1  fetch request accepted this cycle
- if_resp_valid  out  1  fetch response
- if_resp_rdata  out  32  fetch read data
- if_resp_err  out  1  fetch request rejected
- d_req_valid  in  1  data request
- d_req_addr  in  32  data byte address
- d_req_we  in  1  1 = write, 0 = read
- d_req_wdata  in  `MEM_DATA_WIDTH  write data
- d_req_ready  out  1  data request accepted this cycle
- d_resp_valid  out  1  data response
- d_resp_rdata  out  32  data read data
- d_resp_err  out  1  data request rejected
- mem_addr  out  32  to memory addr
- mem_wdata  out  `MEM_DATA_WIDTH  to memory wdata
- mem_rw  out  1  to memory mem_rw (write enable)
- mem_rdata  in  32  from memory rdata, valid one cycle after issue

Behaviour:
- Reset: clk and reset are as already decided (clock clk; reset reset, synchronous, active-high).
  - While reset is high: if_req_ready = d_req_ready = 0, mem_rw = 0, mem_addr = 0.
  - Registered state after reset: resp_valid flags 0, err flags 0, owner = none, starve_cnt = 0.
  - Any in-flight response is dropped and never appears after reset deasserts.
- Handshake: a request is accepted when valid && ready at a posedge. Ready is combinational from the valids and starve_cnt, with no dependency on ready.
- Requesters must hold valid, addr, we and wdata stable until accepted. Responses cannot be backpressured.
- Arbitration, per cycle:
  - Only one valid: that port is granted.
  - Both valid: data is granted unless starve_cnt == STARVE_LIMIT, in which case fetch is granted.
- Starvation counter (starve_cnt):
  - Increments, saturating at STARVE_LIMIT, when fetch is valid and loses.
  - Clears to 0 when fetch is granted or fetch is not valid.
- Issue, grant cycle N:
  - mem_addr = granted addr.
  - mem_wdata = d_req_wdata.
  - mem_rw = d_req_we && data granted && no error.
  - With no grant: mem_rw = 0 and mem_addr = 0.
- Error check: err = (addr[1:0] != 0) || (ADDR_CHECK && addr[31:`MEM_ADDR_WIDTH+2] != 0).
  - An erroring request is still accepted, but forces mem_rw = 0.
  - Its response carries err = 1 and rdata = 0.
- Response, cycle N+1:
  - Owner port's resp_valid = 1 for exactly one cycle; the other port's resp_valid = 0.
  - rdata = mem_rdata when no error, else 0.
  - For a write, d_resp_valid still pulses as the write ack. d_resp_rdata is the pre-write word, because memory reads before it writes.
- Throughput: one accepted request per cycle, back-to-back, with no bubble. The response for cycle N and the issue for cycle N+1 overlap.
- Same-address write then read on consecutive cycles: the read returns the new data.
- Inactive port's rdata and err outputs are held at 0.

Decomposition:
- Shared package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} mem_owner_t`.
  - Error-check function addr_err(addr, check).
  - Uses `MEM_ADDR_WIDTH` and `MEM_DATA_WIDTH` from riscv_defines.vh.
- One sub-module, `mem_arb_starve_ctr`: saturating counter with inputs lose and win/idle and output at_limit.

Test Plan:
- Fetch only, addrs 0x0, 0x4, 0x8 back-to-back (mem preloaded 0x11, 0x22, 0x33) -> if_req_ready = 1 every cycle; if_resp_rdata = 0x11, 0x22, 0x33 on cycles N+1..N+3.
- Data write 0x8 = 0xDEADBEEF, then read 0x8 next cycle -> write ack carries old word; read returns 0xDEADBEEF; if_resp_valid = 0 throughout.
- Both valid continuously, STARVE_LIMIT = 4 -> grant pattern D, D, D, D, IF, then repeats; fetch never waits more than 4 cycles.
- Data read addr 0x6 -> accepted; mem_rw = 0; d_resp_err = 1 and d_resp_rdata = 0 next cycle. Data write to 0x8000_0000 with ADDR_CHECK = 1 -> err = 1 and memory unchanged.
- Reset asserted the cycle after an accepted read -> no resp_valid appears; after deassert, the ready outputs follow the valids again and starve_cnt = 0.
- No valids for 3 cycles -> mem_rw = 0, mem_addr = 0, all resp_valid = 0.
